// File: rtl/sobel_pkg.sv
// Shared FSM state type and default geometry for the Sobel frame controller.
package sobel_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 8;
    localparam int unsigned DefAw    = 6;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StScan,
        StWait,
        StEmit,
        StDone
    } state_e;

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// Handshake bundle between the frame controller (master) and its pixel source,
// frame buffer, kernel engine and result sink (slave).
interface sobel_frame_ctrl_if
    import sobel_pkg::*;
#(
    parameter int unsigned AW = DefAw
);

    logic          pix_valid;
    logic [7:0]    pix_data;
    logic          pix_ready;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    logic          k_start;
    logic [AW-1:0] k_addr;
    logic          k_done;
    logic [7:0]    k_sum;

    logic          edge_valid;
    logic          edge_bit;
    logic [AW-1:0] edge_addr;
    logic          edge_ready;

    modport master (
        input  pix_valid, pix_data, k_done, k_sum, edge_ready,
        output pix_ready, mem_we, mem_waddr, mem_wdata,
        output k_start, k_addr, edge_valid, edge_bit, edge_addr
    );

    modport slave (
        output pix_valid, pix_data, k_done, k_sum, edge_ready,
        input  pix_ready, mem_we, mem_waddr, mem_wdata,
        input  k_start, k_addr, edge_valid, edge_bit, edge_addr
    );

endinterface

// File: rtl/sobel_scan_cnt.sv
// Raster X/Y walker with a linear address kept alongside, so no multiplier is
// needed to form Y*WIDTH+X.
module sobel_scan_cnt
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned AW    = DefAw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [AW-1:0] addr,
    output logic          last,
    output logic          boundary
);

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned YW = $clog2(DEPTH);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [AW-1:0] addr_q;
    logic          x_last;
    logic          y_last;

    assign x_last   = x_q == XW'(WIDTH - 1);
    assign y_last   = y_q == YW'(DEPTH - 1);
    assign last     = x_last && y_last;
    assign boundary = (x_q == '0) || x_last || (y_q == '0) || y_last;
    assign addr     = addr_q;

    // Advancing past the final pixel wraps to the origin so the next frame starts clean.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else if (adv) begin
            if (last) begin
                x_q    <= '0;
                y_q    <= '0;
                addr_q <= '0;
            end else if (x_last) begin
                x_q    <= '0;
                y_q    <= y_q + 1'b1;
                addr_q <= addr_q + 1'b1;
            end else begin
                x_q    <= x_q + 1'b1;
                addr_q <= addr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Sobel frame controller: buffers one raster frame, then walks it, requesting a
// kernel result per interior pixel and streaming thresholded edge bits in order.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned AW    = DefAw
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         threshold,
    sobel_frame_ctrl_if.master bus,
    output logic               busy,
    output logic               done
);

    localparam logic [AW-1:0] LastAddr = AW'(WIDTH * DEPTH - 1);

    state_e        state_q;
    logic [7:0]    thr_q;
    logic [AW-1:0] load_cnt_q;
    logic          edge_q;

    logic          beat;
    logic          cnt_clr;
    logic          cnt_adv;
    logic [AW-1:0] scan_addr;
    logic          scan_last;
    logic          scan_bnd;

    assign beat    = (state_q == StLoad) && bus.pix_valid;
    assign cnt_clr = (state_q == StIdle) && start;
    assign cnt_adv = (state_q == StEmit) && bus.edge_ready;

    sobel_scan_cnt #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scan_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .adv      (cnt_adv),
        .addr     (scan_addr),
        .last     (scan_last),
        .boundary (scan_bnd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            thr_q      <= '0;
            load_cnt_q <= '0;
            edge_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        thr_q      <= threshold;
                        load_cnt_q <= '0;
                        edge_q     <= 1'b0;
                        state_q    <= StLoad;
                    end
                end
                StLoad: begin
                    if (beat) begin
                        if (load_cnt_q == LastAddr) begin
                            load_cnt_q <= '0;
                            state_q    <= StScan;
                        end else begin
                            load_cnt_q <= load_cnt_q + 1'b1;
                        end
                    end
                end
                StScan: begin
                    // Border pixels have no full 3x3 neighbourhood: emit a zero directly.
                    if (scan_bnd) begin
                        edge_q  <= 1'b0;
                        state_q <= StEmit;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (bus.k_done) begin
                        edge_q  <= bus.k_sum > thr_q;
                        state_q <= StEmit;
                    end
                end
                StEmit: begin
                    if (bus.edge_ready) begin
                        state_q <= scan_last ? StDone : StScan;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // The write port is a straight pass-through of the accepted beat.
    assign bus.pix_ready  = state_q == StLoad;
    assign bus.mem_we     = beat;
    assign bus.mem_waddr  = load_cnt_q;
    assign bus.mem_wdata  = bus.pix_data;

    assign bus.k_start    = (state_q == StScan) && !scan_bnd;
    assign bus.k_addr     = scan_addr;

    assign bus.edge_valid = state_q == StEmit;
    assign bus.edge_bit   = edge_q;
    assign bus.edge_addr  = scan_addr;

    assign busy           = state_q != StIdle;
    assign done           = state_q == StDone;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed-plus-random bench for sobel_frame_ctrl on a 4x4 frame with a
// transaction-level model of the expected pixel/kernel/result sequence.
module tb_sobel_frame_ctrl;

    localparam int unsigned W = 4;
    localparam int unsigned D = 4;
    localparam int unsigned A = 4;
    localparam int unsigned N = W * D;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] threshold = 8'h0;
    logic       busy;
    logic       done;

    sobel_frame_ctrl_if #(.AW(A)) bus ();

    sobel_frame_ctrl #(
        .WIDTH (W),
        .DEPTH (D),
        .AW    (A)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .threshold (threshold),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] pix  [N];
    logic [7:0] ksum [N];
    int         kdel [N];
    int         stall[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic bit interior(input int a);
        int x = a % W;
        int y = a / W;
        return (x != 0) && (x != W - 1) && (y != 0) && (y != D - 1);
    endfunction

    function automatic bit exp_edge(input int a, input logic [7:0] thr);
        return interior(a) && (ksum[a] > thr);
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_pix_ready"}, bus.pix_ready, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_k_start"}, bus.k_start, 0);
        chk({tag, "_edge_valid"}, bus.edge_valid, 0);
        chk({tag, "_edge_bit"}, bus.edge_bit, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_waddr"}, bus.mem_waddr, 0);
        chk({tag, "_k_addr"}, bus.k_addr, 0);
        chk({tag, "_edge_addr"}, bus.edge_addr, 0);
    endtask

    task automatic fill_frame();
        for (int i = 0; i < N; i++) begin
            pix[i]   = 8'($urandom);
            ksum[i]  = 8'($urandom);
            kdel[i]  = $urandom_range(3);
            stall[i] = $urandom_range(2);
        end
    endtask

    task automatic run_frame(input logic [7:0] thr, input bit gaps, input bit spurious,
                             input bit poke, input int abort_addr);
        int a     = 0;
        int guard = 0;
        threshold = thr;
        start     = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_pix_ready", bus.pix_ready, 0);
        nxt();
        start = 1'b0;

        while (a < N && guard < 200) begin
            guard++;
            if (gaps && $urandom_range(3) == 0) begin
                bus.pix_valid = 1'b0;
                bus.pix_data  = 8'($urandom);
            end else begin
                bus.pix_valid = 1'b1;
                bus.pix_data  = pix[a];
            end
            @(negedge clk);
            chk("load_ready", bus.pix_ready, 1);
            chk("load_busy", busy, 1);
            chk("load_we", bus.mem_we, bus.pix_valid);
            if (bus.pix_valid) begin
                chk("load_waddr", bus.mem_waddr, a);
                chk("load_wdata", bus.mem_wdata, pix[a]);
                a++;
            end
            nxt();
        end
        bus.pix_valid = 1'b0;
        if (a < N) chk("load_timeout", a, N);

        for (int p = 0; p < N; p++) begin
            if (spurious) begin
                bus.k_done = 1'b1;
                bus.k_sum  = 8'hff;
            end
            @(negedge clk);
            chk("scan_k_start", bus.k_start, interior(p));
            chk("scan_edge_valid", bus.edge_valid, 0);
            chk("scan_pix_ready", bus.pix_ready, 0);
            if (interior(p)) chk("scan_k_addr", bus.k_addr, p);
            nxt();
            bus.k_done = 1'b0;

            if (interior(p)) begin
                for (int d = 0; d < kdel[p]; d++) begin
                    if (poke && p == 6 && d == 0) begin
                        threshold = 8'h0;
                        start     = 1'b1;
                    end
                    @(negedge clk);
                    chk("wait_k_start", bus.k_start, 0);
                    chk("wait_edge_valid", bus.edge_valid, 0);
                    nxt();
                    start = 1'b0;
                end
                if (p == abort_addr) begin
                    rst        = 1'b1;
                    bus.k_done = 1'b1;
                    bus.k_sum  = 8'hff;
                    nxt();
                    rst        = 1'b0;
                    bus.k_done = 1'b0;
                    @(negedge clk);
                    check_quiet("abort");
                    nxt();
                    return;
                end
                bus.k_done = 1'b1;
                bus.k_sum  = ksum[p];
                @(negedge clk);
                chk("kdone_edge_valid", bus.edge_valid, 0);
                nxt();
                bus.k_done = 1'b0;
                bus.k_sum  = 8'($urandom);
            end

            for (int s = 0; s <= stall[p]; s++) begin
                bus.edge_ready = (s == stall[p]);
                if (spurious) begin
                    bus.k_done = 1'b1;
                    bus.k_sum  = ~ksum[p];
                end
                @(negedge clk);
                chk("emit_valid", bus.edge_valid, 1);
                chk("emit_bit", bus.edge_bit, exp_edge(p, thr));
                chk("emit_addr", bus.edge_addr, p);
                chk("emit_k_start", bus.k_start, 0);
                chk("emit_done", done, 0);
                nxt();
            end
            bus.edge_ready = 1'b0;
            bus.k_done     = 1'b0;
        end

        start = 1'b1;
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_edge_valid", bus.edge_valid, 0);
        nxt();
        start = 1'b0;
        @(negedge clk);
        chk("after_done", done, 0);
        chk("after_busy", busy, 0);
        nxt();
    endtask

    initial begin
        bus.pix_valid  = 1'b0;
        bus.pix_data   = 8'h0;
        bus.k_done     = 1'b0;
        bus.k_sum      = 8'h0;
        bus.edge_ready = 1'b0;
        rst            = 1'b1;
        start          = 1'b1;
        threshold      = 8'h33;
        nxt();
        nxt();
        @(negedge clk);
        check_quiet("reset");
        nxt();
        rst   = 1'b0;
        start = 1'b0;

        // Directed frame: ramp pixels, near-threshold sums, stall, late kernel, spurious k_done.
        for (int i = 0; i < N; i++) begin
            pix[i]   = 8'(i);
            ksum[i]  = 8'($urandom);
            kdel[i]  = 0;
            stall[i] = 0;
        end
        ksum[5]  = 8'd51;
        ksum[10] = 8'd51;
        ksum[6]  = 8'd50;
        ksum[9]  = 8'd50;
        kdel[9]  = 10;
        stall[6] = 5;
        run_frame(8'd50, 1'b0, 1'b1, 1'b0, -1);

        // Threshold dropped to 0 and start pulsed mid-frame.
        fill_frame();
        kdel[6] = 2;
        run_frame(8'd50, 1'b1, 1'b0, 1'b1, -1);

        // Reset while waiting on the kernel at address 6, then a clean frame.
        fill_frame();
        run_frame(8'd50, 1'b0, 1'b0, 1'b0, 6);

        for (int f = 0; f < 3; f++) begin
            fill_frame();
            run_frame(8'($urandom), 1'b1, f[0], 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, frame width in pixels (>=3).
REQ-002 Parameter DEPTH, default 8, frame height in pixels (>=3).
REQ-003 Parameter AW, default 6, pixel address width; WIDTH*DEPTH <= 2**AW.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  frame request, sampled only in IDLE.
REQ-007 threshold  in  8  edge threshold, latched on accepted start.
REQ-008 pix_valid  in  1 / pix_data  in  8 / pix_ready  out  1  raster-order pixel input stream.
REQ-009 mem_we  out  1 / mem_waddr  out  AW / mem_wdata  out  8  frame-buffer write port.
REQ-010 k_start  out  1 / k_addr  out  AW  kernel request, centre-pixel address.
REQ-011 k_done  in  1 / k_sum  in  8  kernel completion pulse and gradient magnitude.
REQ-012 edge_valid  out  1 / edge_bit  out  1 / edge_addr  out  AW / edge_ready  in  1  result stream.
REQ-013 busy  out  1  high whenever state != IDLE.
REQ-014 done  out  1  one-cycle pulse at frame completion.

Function
REQ-015 FSM states: IDLE, LOAD, SCAN, WAIT, EMIT, DONE.
REQ-016 IDLE: start=1 -> latch threshold into thr_q, clear counters, -> LOAD next cycle; start ignored in all other states.
REQ-017 LOAD: pix_ready=1; each pix_valid&pix_ready beat drives mem_we=1, mem_waddr=load count, mem_wdata=pix_data in the same cycle (combinational), count+1.
REQ-018 LOAD: beat with count == WIDTH*DEPTH-1 -> SCAN at X=0, Y=0; pix_ready=0 outside LOAD.
REQ-019 SCAN, boundary (X==0, X==WIDTH-1, Y==0 or Y==DEPTH-1): edge_q=0, no kernel request, -> EMIT next cycle.
REQ-020 SCAN, interior: k_start=1 for exactly one cycle, k_addr=Y*WIDTH+X, -> WAIT.
REQ-021 WAIT: on k_done=1, edge_q = (k_sum > thr_q), strict unsigned compare, -> EMIT; no timeout, waits indefinitely.
REQ-022 k_done outside WAIT ignored; k_done in the SCAN cycle that issues k_start ignored (earliest accepted k_done is next cycle).
REQ-023 EMIT: edge_valid=1, edge_bit=edge_q, edge_addr=Y*WIDTH+X, all held stable until edge_ready=1.
REQ-024 EMIT handshake: if X<WIDTH-1 then X+1, else X=0, Y+1; -> SCAN; if (X,Y)==(WIDTH-1,DEPTH-1) -> DONE instead.
REQ-025 DONE: done=1 one cycle, -> IDLE; start in the DONE cycle ignored.
REQ-026 Latency: boundary pixel edge_valid 1 cycle after SCAN entry; interior pixel edge_valid 1 cycle after accepted k_done.
REQ-027 Results emitted strictly in raster order, exactly WIDTH*DEPTH per frame.
REQ-028 threshold changes after start have no effect on current frame.

Reset
REQ-029 rst=1 at any clock edge, including mid-LOAD/WAIT/EMIT: state=IDLE, counters and thr_q cleared; frame abandoned, not resumed.
REQ-030 Reset values: pix_ready, mem_we, k_start, edge_valid, edge_bit, busy, done = 0; mem_waddr, k_addr, edge_addr = 0.
REQ-031 rst has priority over start and all handshakes in the same cycle.

Structure
REQ-032 Package sobel_pkg holds the FSM state enum and default WIDTH/DEPTH/AW constants.
REQ-033 One sub-module, sobel_scan_cnt: X/Y raster counter with clear, advance, last and boundary flags, linear address output.
REQ-034 No multiplier in the address path: linear address kept as incrementing counter alongside X/Y.

Verification (WIDTH=4, DEPTH=4, AW=4)
REQ-035 Load 16 pixels value 0..15 continuous valid -> 16 writes, mem_waddr 0..15, SCAN entered next cycle.
REQ-036 threshold=50, kernel model returns k_sum=51 for addr 5,10 and 50 for addr 6,9 -> k_start only at 5,6,9,10; edge_bit=1 only at addr 5,10; done pulse after addr 15.
REQ-037 edge_ready held low 5 cycles at addr 6 -> edge_valid/edge_bit/edge_addr stable 5 cycles, no k_start issued meanwhile.
REQ-038 k_done delayed 10 cycles for addr 9, spurious k_done during EMIT -> spurious pulse ignored, result order unchanged.
REQ-039 rst asserted in WAIT at addr 6 -> next cycle all outputs 0, busy=0; new start runs full clean frame.
REQ-040 threshold changed 50->0 mid-frame, start pulsed while busy -> results use 50, second frame not launched.
